// File: rtl/ip_codma_pkg.sv
// rtl/ip_codma_pkg.sv - Shared CODMA types and constants
package ip_codma_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_ASK     = 2'd1,
        ARB_GRANTED = 2'd2,
        ARB_RELEASE = 2'd3
    } arb_state_t;

    // Size code presented on the bus whenever nobody owns it.
    localparam logic [3:0] SIZE_IDLE = 4'd9;

endpackage

// File: rtl/ip_codma_rr_picker.sv
// rtl/ip_codma_rr_picker.sv - Combinational round-robin winner select
module ip_codma_rr_picker #(
    parameter int NUM_REQ = 3,
    parameter int PTR_W   = 2
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [PTR_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] winner_o,
    output logic               valid_o
);

    int idx;

    // Scan cyclically starting at ptr_i; the first set request wins.
    always_comb begin
        winner_o = '0;
        valid_o  = 1'b0;
        idx      = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = int'(ptr_i) + i;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!valid_o && req_i[idx]) begin
                winner_o[idx] = 1'b1;
                valid_o       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ip_codma_bus_arbiter.sv
// rtl/ip_codma_bus_arbiter.sv - Round-robin owner of the CODMA memory-bus master port
// Optional grant watchdog enabled by defining CODMA_ARB_TIMEOUT_EN.
module ip_codma_bus_arbiter
    import ip_codma_pkg::*;
#(
    parameter int NUM_REQ        = 3,
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 64,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    input  logic                      abort_i,
    input  logic [NUM_REQ-1:0]        req_i,
    input  logic [NUM_REQ-1:0]        rd_nwr_i,
    input  logic [NUM_REQ*ADDR_W-1:0] addr_i,
    input  logic [NUM_REQ*4-1:0]      size_i,
    input  logic [NUM_REQ*DATA_W-1:0] wdata_i,
    output logic [NUM_REQ-1:0]        gnt_o,
    output logic [NUM_REQ-1:0]        done_o,
    output logic                      bus_read_o,
    output logic                      bus_write_o,
    output logic                      bus_write_valid_o,
    output logic [ADDR_W-1:0]         bus_addr_o,
    output logic [3:0]                bus_size_o,
    output logic [DATA_W-1:0]         bus_wdata_o,
    input  logic                      bus_grant_i,
    input  logic                      bus_done_i,
    output logic                      arb_error_o
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [NUM_REQ-1:0] ONE_HOT_0 = NUM_REQ'(1);

    arb_state_t         state_q, state_d;
    logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0]   owner_q, owner_d;
    logic               rd_nwr_q, rd_nwr_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [3:0]         size_q, size_d;

    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [NUM_REQ-1:0] done_q, done_d;
    logic               bus_read_q, bus_read_d;
    logic               bus_write_q, bus_write_d;
    logic               bus_wvalid_q, bus_wvalid_d;
    logic [ADDR_W-1:0]  bus_addr_q, bus_addr_d;
    logic [3:0]         bus_size_q, bus_size_d;
    logic [DATA_W-1:0]  bus_wdata_q, bus_wdata_d;
    logic               err_q, err_d;

    logic [NUM_REQ-1:0] pick_oh;
    logic               pick_valid;
    logic [PTR_W-1:0]   pick_idx;
    logic [PTR_W-1:0]   next_ptr;
    logic               finish;
    logic               expire;
    logic               timeout_hit;
    logic               bus_owned;

    ip_codma_rr_picker #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_picker (
        .req_i    (req_i),
        .ptr_i    (rr_ptr_q),
        .winner_o (pick_oh),
        .valid_o  (pick_valid)
    );

    always_comb begin
        pick_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick_oh[i]) begin
                pick_idx = PTR_W'(i);
            end
        end
    end

    assign next_ptr = (owner_q == PTR_W'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;

`ifdef CODMA_ARB_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    // Counts consecutive cycles in one bus-holding state; any state change restarts it.
    always_comb begin
        cnt_d = '0;
        if ((state_d == state_q) && ((state_q == ARB_ASK) || (state_q == ARB_GRANTED))) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
    assign timeout_hit        = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q      <= ARB_IDLE;
            rr_ptr_q     <= '0;
            owner_q      <= '0;
            rd_nwr_q     <= 1'b0;
            addr_q       <= '0;
            size_q       <= '0;
            gnt_q        <= '0;
            done_q       <= '0;
            bus_read_q   <= 1'b0;
            bus_write_q  <= 1'b0;
            bus_wvalid_q <= 1'b0;
            bus_addr_q   <= '0;
            bus_size_q   <= SIZE_IDLE;
            bus_wdata_q  <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            owner_q      <= owner_d;
            rd_nwr_q     <= rd_nwr_d;
            addr_q       <= addr_d;
            size_q       <= size_d;
            gnt_q        <= gnt_d;
            done_q       <= done_d;
            bus_read_q   <= bus_read_d;
            bus_write_q  <= bus_write_d;
            bus_wvalid_q <= bus_wvalid_d;
            bus_addr_q   <= bus_addr_d;
            bus_size_q   <= bus_size_d;
            bus_wdata_q  <= bus_wdata_d;
            err_q        <= err_d;
        end
    end

    // Priority inside a state: abort, then the bus event, then withdraw, then watchdog.
    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        owner_d  = owner_q;
        rd_nwr_d = rd_nwr_q;
        addr_d   = addr_q;
        size_d   = size_q;
        finish   = 1'b0;
        expire   = 1'b0;
        unique case (state_q)
            ARB_IDLE: begin
                if (!abort_i && pick_valid) begin
                    state_d  = ARB_ASK;
                    owner_d  = pick_idx;
                    rd_nwr_d = rd_nwr_i[pick_idx];
                    addr_d   = addr_i[pick_idx*ADDR_W +: ADDR_W];
                    size_d   = size_i[pick_idx*4 +: 4];
                end
            end
            ARB_ASK: begin
                if (abort_i) begin
                    state_d = ARB_RELEASE;
                end else if (bus_grant_i) begin
                    state_d = ARB_GRANTED;
                end else if (!req_i[owner_q]) begin
                    state_d = ARB_IDLE;
                end else if (timeout_hit) begin
                    state_d  = ARB_RELEASE;
                    expire   = 1'b1;
                    rr_ptr_d = next_ptr;
                end
            end
            ARB_GRANTED: begin
                if (abort_i) begin
                    state_d = ARB_RELEASE;
                end else if (bus_done_i) begin
                    state_d  = ARB_RELEASE;
                    finish   = 1'b1;
                    rr_ptr_d = next_ptr;
                end else if (timeout_hit) begin
                    state_d  = ARB_RELEASE;
                    expire   = 1'b1;
                    rr_ptr_d = next_ptr;
                end
            end
            ARB_RELEASE: begin
                state_d = ARB_IDLE;
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    assign bus_owned = (state_d == ARB_ASK) || (state_d == ARB_GRANTED);

    // Registered bus outputs are a pure function of the upcoming state and latched owner.
    always_comb begin
        bus_read_d   = (state_d == ARB_ASK) && rd_nwr_d;
        bus_write_d  = (state_d == ARB_ASK) && !rd_nwr_d;
        bus_wvalid_d = (state_d == ARB_GRANTED) && !rd_nwr_d;
        bus_addr_d   = bus_owned ? addr_d : '0;
        bus_size_d   = bus_owned ? size_d : SIZE_IDLE;
        bus_wdata_d  = bus_wvalid_d ? wdata_i[owner_d*DATA_W +: DATA_W] : '0;
        gnt_d        = (state_d == ARB_GRANTED) ? (ONE_HOT_0 << owner_d) : '0;
        done_d       = finish ? (ONE_HOT_0 << owner_q) : '0;
        err_d        = expire;
    end

    assign gnt_o             = gnt_q;
    assign done_o            = done_q;
    assign bus_read_o        = bus_read_q;
    assign bus_write_o       = bus_write_q;
    assign bus_write_valid_o = bus_wvalid_q;
    assign bus_addr_o        = bus_addr_q;
    assign bus_size_o        = bus_size_q;
    assign bus_wdata_o       = bus_wdata_q;
    assign arb_error_o       = err_q;

endmodule

// File: tb/tb_ip_codma_bus_arbiter.sv
// tb/tb_ip_codma_bus_arbiter.sv - Self-checking bench for ip_codma_bus_arbiter
module tb_ip_codma_bus_arbiter;

    localparam int N  = 3;
    localparam int AW = 32;
    localparam int DW = 64;
    localparam int TO = 16;
`ifdef CODMA_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            reset_i, abort_i;
    logic [N-1:0]    req_i, rd_nwr_i;
    logic [N*AW-1:0] addr_i;
    logic [N*4-1:0]  size_i;
    logic [N*DW-1:0] wdata_i;
    logic [N-1:0]    gnt_o, done_o;
    logic            bus_read_o, bus_write_o, bus_write_valid_o;
    logic [AW-1:0]   bus_addr_o;
    logic [3:0]      bus_size_o;
    logic [DW-1:0]   bus_wdata_o;
    logic            bus_grant_i, bus_done_i, arb_error_o;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ip_codma_bus_arbiter #(
        .NUM_REQ        (N),
        .ADDR_W         (AW),
        .DATA_W         (DW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk_i             (clk),
        .reset_i           (reset_i),
        .abort_i           (abort_i),
        .req_i             (req_i),
        .rd_nwr_i          (rd_nwr_i),
        .addr_i            (addr_i),
        .size_i            (size_i),
        .wdata_i           (wdata_i),
        .gnt_o             (gnt_o),
        .done_o            (done_o),
        .bus_read_o        (bus_read_o),
        .bus_write_o       (bus_write_o),
        .bus_write_valid_o (bus_write_valid_o),
        .bus_addr_o        (bus_addr_o),
        .bus_size_o        (bus_size_o),
        .bus_wdata_o       (bus_wdata_o),
        .bus_grant_i       (bus_grant_i),
        .bus_done_i        (bus_done_i),
        .arb_error_o       (arb_error_o)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        abort_i     = 1'b0;
        req_i       = '0;
        rd_nwr_i    = '0;
        addr_i      = '0;
        size_i      = '0;
        wdata_i     = '0;
        bus_grant_i = 1'b0;
        bus_done_i  = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset_i = 1'b1;
        tick();
        tick();
        reset_i = 1'b0;
    endtask

    task automatic set_req(input int i, input logic rd, input logic [AW-1:0] a,
                           input logic [3:0] s, input logic [DW-1:0] w);
        rd_nwr_i[i]         = rd;
        addr_i[i*AW +: AW]  = a;
        size_i[i*4 +: 4]    = s;
        wdata_i[i*DW +: DW] = w;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (gnt_o !== 3'b000) begin failures++; $display("FAIL reset_gnt got=%b want=000", gnt_o); end
        checks++; if (done_o !== 3'b000) begin failures++; $display("FAIL reset_done got=%b want=000", done_o); end
        checks++; if ({bus_read_o, bus_write_o, bus_write_valid_o} !== 3'b000) begin failures++; $display("FAIL reset_req got=%b want=000", {bus_read_o, bus_write_o, bus_write_valid_o}); end
        checks++; if (bus_addr_o !== 32'h0) begin failures++; $display("FAIL reset_addr got=%h want=0", bus_addr_o); end
        checks++; if (bus_size_o !== 4'd9) begin failures++; $display("FAIL reset_size got=%0d want=9", bus_size_o); end
        checks++; if (bus_wdata_o !== 64'h0) begin failures++; $display("FAIL reset_wdata got=%h want=0", bus_wdata_o); end
        checks++; if (arb_error_o !== 1'b0) begin failures++; $display("FAIL reset_err got=%b want=0", arb_error_o); end
    endtask

    task automatic test_single_read();
        do_reset();
        set_req(0, 1'b1, 32'h100, 4'd3, 64'h0);
        req_i = 3'b001;
        tick();
        checks++; if ({bus_read_o, bus_write_o} !== 2'b10) begin failures++; $display("FAIL rd_request got=%b want=10", {bus_read_o, bus_write_o}); end
        checks++; if ({bus_addr_o, bus_size_o} !== {32'h100, 4'd3}) begin failures++; $display("FAIL rd_addr_size got=%h/%0d want=100/3", bus_addr_o, bus_size_o); end
        tick();
        bus_grant_i = 1'b1;
        tick();
        bus_grant_i = 1'b0;
        checks++; if ({gnt_o, bus_read_o} !== 4'b0010) begin failures++; $display("FAIL rd_grant got=%b/%b want=001/0", gnt_o, bus_read_o); end
        tick();
        tick();
        bus_done_i = 1'b1;
        tick();
        bus_done_i = 1'b0;
        req_i      = 3'b000;
        checks++; if ({done_o, gnt_o} !== 6'b001000) begin failures++; $display("FAIL rd_done got=%b/%b want=001/000", done_o, gnt_o); end
        checks++; if (bus_size_o !== 4'd9) begin failures++; $display("FAIL rd_size_idle got=%0d want=9", bus_size_o); end
        tick();
        checks++; if (done_o !== 3'b000) begin failures++; $display("FAIL rd_done_pulse got=%b want=000", done_o); end
    endtask

    task automatic test_alternate();
        int owners[$];
        logic [N-1:0] prev_gnt;
        bit overlap;
        do_reset();
        set_req(0, 1'b1, 32'h10, 4'd1, 64'h0);
        set_req(1, 1'b1, 32'h20, 4'd2, 64'h0);
        req_i    = 3'b011;
        prev_gnt = '0;
        overlap  = 1'b0;
        for (int c = 0; c < 80 && owners.size() < 4; c++) begin
            tick();
            if ($countones(gnt_o) > 1 || (gnt_o != 0 && (bus_read_o || bus_write_o))) overlap = 1'b1;
            if (gnt_o != 0 && prev_gnt == 0) owners.push_back(gnt_o[1] ? 1 : (gnt_o[2] ? 2 : 0));
            prev_gnt    = gnt_o;
            bus_grant_i = bus_read_o | bus_write_o;
            bus_done_i  = |gnt_o;
        end
        clear_inputs();
        tick();
        tick();
        checks++; if (owners.size() !== 4) begin failures++; $display("FAIL alt_count got=%0d want=4", owners.size()); end
        for (int i = 0; i < owners.size(); i++) begin
            checks++; if (owners[i] !== (i % 2)) begin failures++; $display("FAIL alt_owner%0d got=%0d want=%0d", i, owners[i], i % 2); end
        end
        checks++; if (overlap !== 1'b0) begin failures++; $display("FAIL alt_overlap got=1 want=0"); end
    endtask

    task automatic test_write_and_abort();
        do_reset();
        set_req(1, 1'b0, 32'h2000, 4'd5, 64'hDEAD_BEEF_0000_0001);
        req_i = 3'b010;
        tick();
        checks++; if ({bus_read_o, bus_write_o} !== 2'b01) begin failures++; $display("FAIL wr_request got=%b want=01", {bus_read_o, bus_write_o}); end
        bus_grant_i = 1'b1;
        tick();
        bus_grant_i = 1'b0;
        checks++; if (gnt_o !== 3'b010) begin failures++; $display("FAIL wr_grant got=%b want=010", gnt_o); end
        checks++; if ({bus_write_valid_o, bus_wdata_o} !== {1'b1, 64'hDEAD_BEEF_0000_0001}) begin failures++; $display("FAIL wr_beat got=%b/%h want=1/deadbeef00000001", bus_write_valid_o, bus_wdata_o); end
        wdata_i[1*DW +: DW] = 64'h0123_4567_89AB_CDEF;
        tick();
        checks++; if ({bus_wdata_o, bus_addr_o} !== {64'h0123_4567_89AB_CDEF, 32'h2000}) begin failures++; $display("FAIL wr_beat_follow got=%h/%h want=0123456789abcdef/2000", bus_wdata_o, bus_addr_o); end
        abort_i    = 1'b1;
        bus_done_i = 1'b1;
        tick();
        clear_inputs();
        checks++; if ({done_o, gnt_o} !== 6'b0) begin failures++; $display("FAIL abort_no_done got=%b/%b want=000/000", done_o, gnt_o); end
        checks++; if ({bus_write_valid_o, bus_write_o, bus_size_o, bus_addr_o} !== {2'b00, 4'd9, 32'h0}) begin failures++; $display("FAIL abort_idle got=%b%b/%0d/%h want=00/9/0", bus_write_valid_o, bus_write_o, bus_size_o, bus_addr_o); end
        tick();
        checks++; if (done_o !== 3'b000) begin failures++; $display("FAIL abort_late_done got=%b want=000", done_o); end
    endtask

    task automatic test_withdraw();
        do_reset();
        set_req(0, 1'b1, 32'h300, 4'd1, 64'h0);
        req_i = 3'b001;
        tick();
        bus_grant_i = 1'b1;
        tick();
        bus_grant_i = 1'b0;
        bus_done_i  = 1'b1;
        tick();
        bus_done_i = 1'b0;
        req_i      = 3'b000;
        tick();
        set_req(2, 1'b0, 32'h500, 4'd2, 64'h5);
        req_i = 3'b100;
        tick();
        checks++; if ({bus_write_o, bus_addr_o} !== {1'b1, 32'h500}) begin failures++; $display("FAIL wd_request got=%b/%h want=1/500", bus_write_o, bus_addr_o); end
        req_i = 3'b000;
        tick();
        checks++; if ({bus_write_o, bus_size_o} !== {1'b0, 4'd9}) begin failures++; $display("FAIL wd_drop got=%b/%0d want=0/9", bus_write_o, bus_size_o); end
        req_i = 3'b101;
        tick();
        checks++; if (bus_addr_o !== 32'h500) begin failures++; $display("FAIL wd_ptr_kept got=%h want=500", bus_addr_o); end
        clear_inputs();
        tick();
        tick();
    endtask

    task automatic test_timeout();
        int first_err;
        logic read_after;
        do_reset();
        set_req(0, 1'b1, 32'h40, 4'd1, 64'h0);
        req_i      = 3'b001;
        first_err  = -1;
        read_after = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (arb_error_o && first_err < 0) begin
                first_err  = k;
                read_after = bus_read_o;
            end
        end
        if (TO_EN) begin
            checks++; if (first_err !== TO + 1) begin failures++; $display("FAIL to_error_cycle got=%0d want=%0d", first_err, TO + 1); end
            checks++; if (read_after !== 1'b0) begin failures++; $display("FAIL to_release got=%b want=0", read_after); end
        end else begin
            checks++; if (first_err !== -1) begin failures++; $display("FAIL to_no_error got=%0d want=-1", first_err); end
            checks++; if (bus_read_o !== 1'b1) begin failures++; $display("FAIL to_still_asking got=%b want=1", bus_read_o); end
        end
        clear_inputs();
        tick();
        tick();
    endtask

    task automatic test_random();
        int ph, own, ptr, age;
        logic m_rd;
        logic [AW-1:0] m_addr;
        logic [3:0] m_size;
        logic [N-1:0] e_done;
        logic e_err;
        logic [109:0] exp_v, act_v;
        do_reset();
        ph = 0; own = 0; ptr = 0; age = 0;
        m_rd = 1'b0; m_addr = '0; m_size = '0;
        for (int cyc = 0; cyc < 500; cyc++) begin
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 7) == 0) req_i[i] = ~req_i[i];
            end
            rd_nwr_i    = N'($urandom);
            addr_i      = {$urandom, $urandom, $urandom};
            for (int i = 0; i < N; i++) size_i[i*4 +: 4] = 4'($urandom_range(0, 8));
            wdata_i     = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            bus_grant_i = ($urandom_range(0, 2) == 0);
            bus_done_i  = ($urandom_range(0, 2) == 0);
            abort_i     = ($urandom_range(0, 31) == 0);

            e_done = '0;
            e_err  = 1'b0;
            if (ph == 0) begin
                if (!abort_i && req_i != 0) begin
                    bit found = 1'b0;
                    for (int k = 0; k < N; k++) begin
                        int c = (ptr + k) % N;
                        if (!found && req_i[c]) begin
                            own = c;
                            found = 1'b1;
                        end
                    end
                    m_rd   = rd_nwr_i[own];
                    m_addr = addr_i[own*AW +: AW];
                    m_size = size_i[own*4 +: 4];
                    ph = 1; age = 0;
                end
            end else if (ph == 1) begin
                if (abort_i) ph = 3;
                else if (bus_grant_i) begin ph = 2; age = 0; end
                else if (!req_i[own]) ph = 0;
                else if (TO_EN && age == TO - 1) begin e_err = 1'b1; ph = 3; ptr = (own + 1) % N; end
                else age++;
            end else if (ph == 2) begin
                if (abort_i) ph = 3;
                else if (bus_done_i) begin e_done = N'(1) << own; ptr = (own + 1) % N; ph = 3; end
                else if (TO_EN && age == TO - 1) begin e_err = 1'b1; ph = 3; ptr = (own + 1) % N; end
                else age++;
            end else begin
                ph = 0;
            end

            exp_v = {(ph == 2) ? (N'(1) << own) : N'(0),
                     e_done,
                     (ph == 1) && m_rd,
                     (ph == 1) && !m_rd,
                     (ph == 2) && !m_rd,
                     (ph == 1 || ph == 2) ? m_addr : 32'h0,
                     (ph == 1 || ph == 2) ? m_size : 4'd9,
                     ((ph == 2) && !m_rd) ? wdata_i[own*DW +: DW] : 64'h0,
                     e_err};
            tick();
            act_v = {gnt_o, done_o, bus_read_o, bus_write_o, bus_write_valid_o,
                     bus_addr_o, bus_size_o, bus_wdata_o, arb_error_o};
            checks++;
            if (act_v !== exp_v) begin
                failures++;
                $display("FAIL rand_cycle%0d got=%h want=%h", cyc, act_v, exp_v);
            end
        end
        clear_inputs();
        tick();
        tick();
    endtask

    task automatic test_mid_reset();
        do_reset();
        set_req(2, 1'b1, 32'h900, 4'd4, 64'h0);
        req_i = 3'b100;
        tick();
        bus_grant_i = 1'b1;
        tick();
        bus_grant_i = 1'b0;
        reset_i     = 1'b1;
        bus_done_i  = 1'b1;
        tick();
        reset_i    = 1'b0;
        bus_done_i = 1'b0;
        req_i      = 3'b000;
        checks++; if ({done_o, gnt_o, bus_size_o} !== {6'b0, 4'd9}) begin failures++; $display("FAIL midreset got=%b/%b/%0d want=000/000/9", done_o, gnt_o, bus_size_o); end
    endtask

    initial begin
        reset_i = 1'b1;
        clear_inputs();
        test_reset();
        test_single_read();
        test_alternate();
        test_write_and_abort();
        test_withdraw();
        test_timeout();
        test_mid_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
